// File: rtl/mprj_wb_mailbox.sv
// Wishbone mailbox responder: CTRL, STATUS, DATA FIFO and SCRATCH in a 16-byte window.
// Define MPRJ_MBOX_IRQ_EN to add CTRL.ien storage and the registered irq_o output.
module mprj_wb_mailbox #(
   parameter logic [31:0] BASE_ADR    = 32'h3000_0000,
   parameter int          FIFO_DEPTH  = 8,
   parameter int          WAIT_STATES = 1
) (
   input  logic        core_clk,
   input  logic        core_rstn,
   input  logic        wb_iena,
   input  logic        cyc_i,
   input  logic        stb_i,
   input  logic        we_i,
   input  logic [3:0]  sel_i,
   input  logic [31:0] adr_i,
   input  logic [31:0] dat_i,
   output logic        ack_o,
   output logic [31:0] dat_o
`ifdef MPRJ_MBOX_IRQ_EN
   ,
   output logic        irq_o
`endif
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACK
   } state_t;

   state_t        state_q, state_d;
   logic [2:0]    wcnt_q, wcnt_d;
   logic          req_we_q, req_we_d;
   logic [3:0]    req_sel_q, req_sel_d;
   logic [1:0]    req_reg_q, req_reg_d;
   logic [31:0]   req_dat_q, req_dat_d;
   logic [31:0]   scratch_q, scratch_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;
   logic [31:0]   mem_q [FIFO_DEPTH];
   logic [31:0]   mem_d [FIFO_DEPTH];

   logic        hit;
   logic        empty;
   logic        full;
   logic        ctrl_ien;
   logic [31:0] status_w;
   logic [31:0] rdata;
   logic        commit_wr;
   logic        commit_rd;
   logic        clr;
   logic        unused_ok;

`ifdef MPRJ_MBOX_IRQ_EN
   logic ien_q, ien_d;
   logic irq_q, irq_d;
   assign ctrl_ien = ien_q;
   assign irq_o    = irq_q;
`else
   assign ctrl_ien = 1'b0;
`endif

   assign unused_ok = ^adr_i[1:0];

   assign hit = cyc_i & stb_i & wb_iena &
                (adr_i[31:4] == BASE_ADR[31:4]);

   assign empty = (count_q == '0);
   assign full  = (count_q == DEPTH_C);

   always_comb begin
      status_w       = '0;
      status_w[0]    = empty;
      status_w[1]    = full;
      status_w[2]    = ovf_q;
      status_w[3]    = unf_q;
      status_w[12:8] = 5'(count_q);
   end

   // Read mux sees pre-commit state, so STATUS and pop data reflect this ACK's start.
   always_comb begin
      rdata = '0;
      case (req_reg_q)
         2'd0: rdata = {31'b0, ctrl_ien};
         2'd1: rdata = status_w;
         2'd2: rdata = empty ? 32'b0 : mem_q[rd_ptr_q];
         2'd3: rdata = scratch_q;
         default: rdata = '0;
      endcase
   end

   assign ack_o = (state_q == S_ACK) & wb_iena;
   assign dat_o = ack_o ? rdata : 32'b0;

   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      req_we_d  = req_we_q;
      req_sel_d = req_sel_q;
      req_reg_d = req_reg_q;
      req_dat_d = req_dat_q;
      case (state_q)
         S_IDLE: begin
            if (hit) begin
               req_we_d  = we_i;
               req_sel_d = sel_i;
               req_reg_d = adr_i[3:2];
               req_dat_d = dat_i;
               if (WAIT_STATES == 0) begin
                  state_d = S_ACK;
               end else begin
                  state_d = S_WAIT;
                  wcnt_d  = 3'(WAIT_STATES - 1);
               end
            end
         end
         S_WAIT: begin
            if (!(cyc_i && stb_i)) begin
               state_d = S_IDLE;
            end else if (wcnt_q == 3'd0) begin
               state_d = S_ACK;
            end else begin
               wcnt_d = wcnt_q - 3'd1;
            end
         end
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign commit_wr = (state_q == S_ACK) &  req_we_q;
   assign commit_rd = (state_q == S_ACK) & ~req_we_q;

   always_comb begin
      scratch_d = scratch_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      mem_d     = mem_q;
      clr       = 1'b0;
`ifdef MPRJ_MBOX_IRQ_EN
      ien_d     = ien_q;
`endif
      if (commit_wr) begin
         case (req_reg_q)
            2'd0: begin
`ifdef MPRJ_MBOX_IRQ_EN
               ien_d = req_dat_q[0];
`endif
               clr = req_dat_q[1];
            end
            2'd1: begin
               if (req_dat_q[2]) ovf_d = 1'b0;
               if (req_dat_q[3]) unf_d = 1'b0;
            end
            2'd2: begin
               if (full) begin
                  ovf_d = 1'b1;
               end else begin
                  mem_d[wr_ptr_q] = req_dat_q;
                  wr_ptr_d        = wr_ptr_q + 1'b1;
                  count_d         = count_q + 1'b1;
               end
            end
            2'd3: begin
               for (int b = 0; b < 4; b++) begin
                  if (req_sel_q[b]) scratch_d[b*8 +: 8] = req_dat_q[b*8 +: 8];
               end
            end
            default: ;
         endcase
      end
      if (commit_rd && (req_reg_q == 2'd2)) begin
         if (empty) begin
            unf_d = 1'b1;
         end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
         end
      end
      // Clear is applied last so it overrides any flag set in the same cycle.
      if (clr) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
         unf_d    = 1'b0;
      end
   end

`ifdef MPRJ_MBOX_IRQ_EN
   assign irq_d = ien_d & (count_d != '0);

   always_ff @(posedge core_clk or negedge core_rstn) begin
      if (!core_rstn) begin
         ien_q <= 1'b0;
         irq_q <= 1'b0;
      end else begin
         ien_q <= ien_d;
         irq_q <= irq_d;
      end
   end
`endif

   always_ff @(posedge core_clk or negedge core_rstn) begin
      if (!core_rstn) begin
         state_q   <= S_IDLE;
         wcnt_q    <= '0;
         req_we_q  <= 1'b0;
         req_sel_q <= '0;
         req_reg_q <= '0;
         req_dat_q <= '0;
         scratch_q <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         req_we_q  <= req_we_d;
         req_sel_q <= req_sel_d;
         req_reg_q <= req_reg_d;
         req_dat_q <= req_dat_d;
         scratch_q <= scratch_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
      end
   end

endmodule

// File: tb/tb_mprj_wb_mailbox.sv
// Directed self-checking bench for mprj_wb_mailbox.
// Each scenario task does its own comparisons against hand-computed values.
module tb_mprj_wb_mailbox;

   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam int WS = 1;
   localparam int DEPTH = 8;
   localparam logic [31:0] A_CTRL = BASE + 32'h0;
   localparam logic [31:0] A_STAT = BASE + 32'h4;
   localparam logic [31:0] A_DATA = BASE + 32'h8;
   localparam logic [31:0] A_SCR  = BASE + 32'hC;

   logic        clk = 1'b0;
   logic        rstn;
   logic        iena;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] adr;
   logic [31:0] wdat;
   logic        ack;
   logic [31:0] rdat;
   logic        irq;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mprj_wb_mailbox #(
      .BASE_ADR(BASE),
      .FIFO_DEPTH(DEPTH),
      .WAIT_STATES(WS)
   ) dut (
      .core_clk(clk),
      .core_rstn(rstn),
      .wb_iena(iena),
      .cyc_i(cyc),
      .stb_i(stb),
      .we_i(we),
      .sel_i(sel),
      .adr_i(adr),
      .dat_i(wdat),
      .ack_o(ack),
      .dat_o(rdat)
`ifdef MPRJ_MBOX_IRQ_EN
      ,
      .irq_o(irq)
`endif
   );

`ifndef MPRJ_MBOX_IRQ_EN
   assign irq = 1'b0;
`endif

   // One bus access; lat = edges from assert to ack seen (0 = timeout).
   task automatic xfer(input logic w, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output int lat,
                       output logic ack_after);
      cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = d;
      lat = 0; rd = '0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (ack) begin
            lat = i;
            rd = rdat;
            break;
         end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clk); #1;
      ack_after = ack;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      logic [31:0] rd; int lat; logic aa;
      xfer(1'b1, 4'hF, a, d, rd, lat, aa);
      checks++;
      if (lat !== WS + 1) begin
         errors++;
         $display("FAIL wr_ack a=%h: lat=%0d exp=%0d", a, lat, WS + 1);
      end
   endtask

   task automatic rd_chk(input string nm, input logic [31:0] a,
                         input logic [31:0] exp);
      logic [31:0] rd; int lat; logic aa;
      xfer(1'b0, 4'hF, a, 32'h0, rd, lat, aa);
      checks++;
      if (lat !== WS + 1 || rd !== exp) begin
         errors++;
         $display("FAIL %s: lat=%0d data=%h exp lat=%0d data=%h",
                  nm, lat, rd, WS + 1, exp);
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0; iena = 1'b1; cyc = 0; stb = 0; we = 0;
      sel = 0; adr = 0; wdat = 0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (ack !== 1'b0 || rdat !== 32'h0 || irq !== 1'b0) begin
         errors++;
         $display("FAIL reset_out: ack=%b dat=%h irq=%b exp 0/0/0",
                  ack, rdat, irq);
      end
      @(negedge clk); rstn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_scratch();
      logic [31:0] rd; int lat; logic aa;
      xfer(1'b0, 4'hF, A_SCR, 32'h0, rd, lat, aa);
      checks++;
      if (lat !== 2 || rd !== 32'h0) begin
         errors++;
         $display("FAIL scr_reset: lat=%0d data=%h exp lat=2 data=0", lat, rd);
      end
      checks++;
      if (aa !== 1'b0) begin
         errors++;
         $display("FAIL ack_one_cycle: ack=%b exp 0", aa);
      end
      xfer(1'b1, 4'b0011, A_SCR, 32'hA5A5_A5A5, rd, lat, aa);
      rd_chk("scr_lo", A_SCR, 32'h0000_A5A5);
      xfer(1'b1, 4'b1100, A_SCR, 32'h1234_5678, rd, lat, aa);
      rd_chk("scr_hi", A_SCR, 32'h1234_A5A5);
   endtask

   task automatic test_fifo();
      wr(A_DATA, 32'h11);
      wr(A_DATA, 32'h22);
      wr(A_DATA, 32'h33);
      rd_chk("stat_3", A_STAT, 32'h0000_0300);
      rd_chk("pop_11", A_DATA, 32'h11);
      rd_chk("pop_22", A_DATA, 32'h22);
      rd_chk("pop_33", A_DATA, 32'h33);
      rd_chk("pop_empty", A_DATA, 32'h0);
      rd_chk("stat_unf", A_STAT, 32'h0000_0009);
      wr(A_STAT, 32'h8);
      rd_chk("stat_unf_clr", A_STAT, 32'h0000_0001);
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 9; i++) wr(A_DATA, 32'(i));
      rd_chk("stat_full", A_STAT, 32'h0000_0806);
      wr(A_CTRL, 32'h2);
      rd_chk("stat_clr", A_STAT, 32'h0000_0001);
      for (int i = 1; i <= 8; i++) wr(A_DATA, 32'h100 + 32'(i));
      rd_chk("wrap_pop1", A_DATA, 32'h101);
      wr(A_DATA, 32'h1AA);
      rd_chk("stat_refull", A_STAT, 32'h0000_0802);
      for (int i = 2; i <= 8; i++) rd_chk("wrap_pop", A_DATA, 32'h100 + 32'(i));
      rd_chk("wrap_pop_last", A_DATA, 32'h1AA);
      rd_chk("stat_drained", A_STAT, 32'h0000_0001);
   endtask

   task automatic test_miss();
      int acks;
      acks = 0;
      cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF;
      adr = BASE + 32'h28; wdat = 32'hDEAD_BEEF;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         if (ack) acks++;
      end
      adr = BASE + 32'h2C;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         if (ack) acks++;
      end
      cyc = 1'b0; stb = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (acks !== 0) begin
         errors++;
         $display("FAIL miss_ack: acks=%0d exp 0", acks);
      end
      iena = 1'b0;
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_SCR; wdat = 32'hFFFF_FFFF;
      acks = 0;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         if (ack || rdat !== 32'h0) acks++;
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clk); #1;
      iena = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (acks !== 0) begin
         errors++;
         $display("FAIL iena_off: acks=%0d exp 0", acks);
      end
      rd_chk("miss_stat", A_STAT, 32'h0000_0001);
      rd_chk("miss_scr", A_SCR, 32'h1234_A5A5);
   endtask

   task automatic test_abort();
      int acks;
      acks = 0;
      cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF;
      adr = A_DATA; wdat = 32'h5555_0000;
      @(posedge clk); #1;
      checks++;
      if (ack !== 1'b0 || rdat !== 32'h0) begin
         errors++;
         $display("FAIL wait_out: ack=%b dat=%h exp 0/0", ack, rdat);
      end
      stb = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (ack) acks++;
      end
      cyc = 1'b0; we = 1'b0;
      checks++;
      if (acks !== 0) begin
         errors++;
         $display("FAIL abort_ack: acks=%0d exp 0", acks);
      end
      rd_chk("abort_stat", A_STAT, 32'h0000_0001);
   endtask

   task automatic test_ctrl();
      wr(A_CTRL, 32'h1);
`ifdef MPRJ_MBOX_IRQ_EN
      rd_chk("ctrl_ien", A_CTRL, 32'h1);
      wr(A_DATA, 32'h77);
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL irq_set: irq=%b exp 1", irq);
      end
      rd_chk("irq_pop", A_DATA, 32'h77);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_clr: irq=%b exp 0", irq);
      end
      wr(A_CTRL, 32'h0);
`else
      rd_chk("ctrl_noien", A_CTRL, 32'h0);
`endif
      wr(A_CTRL, 32'h2);
      rd_chk("ctrl_clr_rd", A_CTRL, 32'h0);
   endtask

   task automatic test_reset_mid();
      wr(A_DATA, 32'h99);
      rd_chk("mid_pre", A_STAT, 32'h0000_0100);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF;
      adr = A_DATA; wdat = 32'hAAAA_0001;
      @(posedge clk); #1;
      rstn = 1'b0;
      #1;
      checks++;
      if (ack !== 1'b0 || rdat !== 32'h0) begin
         errors++;
         $display("FAIL mid_rst_out: ack=%b dat=%h exp 0/0", ack, rdat);
      end
      repeat (2) @(posedge clk);
      #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(negedge clk); rstn = 1'b1;
      @(posedge clk); #1;
      rd_chk("mid_stat", A_STAT, 32'h0000_0001);
      rd_chk("mid_scr", A_SCR, 32'h0);
      rd_chk("mid_pop", A_DATA, 32'h0);
   endtask

   initial begin
      test_reset();
      test_scratch();
      test_fifo();
      test_overflow();
      test_miss();
      test_abort();
      test_ctrl();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
